// File: rtl/shield_array.sv
// rtl/shield_array.sv - row of erodible, regenerating bunkers drawn from a per-cell HP memory
module shield_array #(
  parameter int NUM_SHIELDS  = 4,
  parameter int TOPLEFT_X    = 96,
  parameter int TOPLEFT_Y    = 356,
  parameter int PITCH_LOG2   = 7,
  parameter int SHIELD_W     = 64,
  parameter int SHIELD_H     = 32,
  parameter int CELL_LOG2    = 2,
  parameter int HP_BITS      = 2,
  parameter int MAX_HP       = 3,
  parameter int PLAYER_DMG   = 1,
  parameter int ALIEN_DMG    = 2,
  parameter int ARCH_ROWS    = 2,
  parameter int REGEN_FRAMES = 60,
  parameter logic [7:0] COLOR_HI = 8'h1C,
  parameter logic [7:0] COLOR_LO = 8'h10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        playGame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        collisionPlayerShot,
  input  logic        collisionAlienShot,
  output logic        shieldDR,
  output logic [7:0]  shieldRGB,
  output logic        clearBusy
);

  localparam int COLS      = SHIELD_W >> CELL_LOG2;
  localparam int ROWS      = SHIELD_H >> CELL_LOG2;
  localparam int CELLS_PER = COLS * ROWS;
  localparam int DEPTH     = NUM_SHIELDS * CELLS_PER;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW        = $clog2(REGEN_FRAMES + 2);
  localparam int HW        = HP_BITS + 2;

  localparam logic [10:0]        X0      = 11'(TOPLEFT_X);
  localparam logic [10:0]        Y0      = 11'(TOPLEFT_Y);
  localparam logic [10:0]        LX_MASK = 11'((1 << PITCH_LOG2) - 1);
  localparam logic [10:0]        SW11    = 11'(SHIELD_W);
  localparam logic [10:0]        SH11    = 11'(SHIELD_H);
  localparam logic [10:0]        NS11    = 11'(NUM_SHIELDS);
  localparam logic [AW-1:0]      LAST    = AW'(DEPTH - 1);
  localparam logic [HP_BITS-1:0] HALF_HP = HP_BITS'(MAX_HP / 2);
  localparam logic [HP_BITS-1:0] FULL_HP = HP_BITS'(MAX_HP);
  localparam logic [FW-1:0]      FR_LAST = FW'(REGEN_FRAMES - 1);
  localparam bit                 REGEN_ON = (REGEN_FRAMES != 0);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_PLAY} state_t;

  // Initial HP of a cell: the middle half of the bottom ARCH_ROWS rows is hollow.
  function automatic logic [HP_BITS-1:0] init_hp(input logic [AW-1:0] a);
    int idx, col, row;
    idx = int'(a);
    col = idx % COLS;
    row = (idx / COLS) % ROWS;
    if (row >= ROWS - ARCH_ROWS && col >= COLS / 4 && col < COLS - COLS / 4)
      return '0;
    return FULL_HP;
  endfunction

  state_t state, state_next;
  logic   in_clear, in_play;

  logic [HP_BITS-1:0] mem [DEPTH];

  logic [10:0]        dx, dy, s_idx, lx, row, col;
  logic               inside_d;
  logic [AW-1:0]      addr_d, addr_q;
  logic [HP_BITS-1:0] rd_pix, hp_d, hp_q;
  logic               dr_d;
  logic [7:0]         rgb_d;

  logic [AW-1:0]      sweep;
  logic [AW-1:0]      regen_ptr;
  logic               regen_pending;
  logic [FW-1:0]      frame_cnt;

  logic [HW-1:0]      dmg, hp_ext;
  logic [HP_BITS-1:0] dmg_hp, ptr_hp, ptr_init, regen_hp;
  logic               damage_we, regen_we;

  logic               we;
  logic [AW-1:0]      waddr;
  logic [HP_BITS-1:0] wdata;

  always_comb begin
    dx       = pixelX - X0;
    dy       = pixelY - Y0;
    s_idx    = dx >> PITCH_LOG2;
    lx       = dx & LX_MASK;
    row      = dy >> CELL_LOG2;
    col      = lx >> CELL_LOG2;
    inside_d = (pixelX >= X0) && (s_idx < NS11) && (lx < SW11) &&
               (pixelY >= Y0) && (dy < SH11);
    addr_d   = '0;
    if (inside_d)
      addr_d = AW'(int'(s_idx) * CELLS_PER + int'(row) * COLS + int'(col));
  end

  // FSM: state register / next-state / outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= ST_CLEAR;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (sweep == LAST) state_next = ST_IDLE;
      ST_IDLE:  if (playGame)      state_next = ST_PLAY;
      ST_PLAY:  if (!playGame)     state_next = ST_CLEAR;
      default:                     state_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    in_clear  = (state == ST_CLEAR);
    in_play   = (state == ST_PLAY);
    clearBusy = in_clear;
  end

  always_comb begin
    dmg       = (collisionPlayerShot ? HW'(PLAYER_DMG) : '0) +
                (collisionAlienShot  ? HW'(ALIEN_DMG)  : '0);
    hp_ext    = HW'(hp_q);
    dmg_hp    = (hp_ext > dmg) ? HP_BITS'(hp_ext - dmg) : '0;
    damage_we = in_play && shieldDR && (collisionPlayerShot || collisionAlienShot);

    ptr_hp    = mem[regen_ptr];
    ptr_init  = init_hp(regen_ptr);
    regen_hp  = (ptr_hp < ptr_init) ? ptr_hp + 1'b1 : ptr_init;
    regen_we  = REGEN_ON && in_play && regen_pending && !damage_we;
  end

  // Single write port: sweep, then damage, then regeneration.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (in_clear) begin
      we    = 1'b1;
      waddr = sweep;
      wdata = init_hp(sweep);
    end else if (damage_we) begin
      we    = 1'b1;
      waddr = addr_q;
      wdata = dmg_hp;
    end else if (regen_we) begin
      we    = 1'b1;
      waddr = regen_ptr;
      wdata = regen_hp;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Forward a same-cycle write so back-to-back hits see the eroded HP.
  always_comb begin
    rd_pix = mem[addr_d];
    hp_d   = (we && waddr == addr_d) ? wdata : rd_pix;
    dr_d   = inside_d && (hp_d != '0) && (state_next != ST_CLEAR);
    rgb_d  = 8'h00;
    if (dr_d) rgb_d = (hp_d > HALF_HP) ? COLOR_HI : COLOR_LO;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addr_q    <= '0;
      hp_q      <= '0;
      shieldDR  <= 1'b0;
      shieldRGB <= 8'h00;
    end else begin
      addr_q    <= addr_d;
      hp_q      <= hp_d;
      shieldDR  <= dr_d;
      shieldRGB <= rgb_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)       sweep <= '0;
    else if (in_clear) sweep <= (sweep == LAST) ? '0 : sweep + 1'b1;
    else               sweep <= '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt     <= '0;
      regen_pending <= 1'b0;
      regen_ptr     <= '0;
    end else if (!in_play || !REGEN_ON) begin
      frame_cnt     <= '0;
      regen_pending <= 1'b0;
    end else begin
      if (regen_we) begin
        regen_pending <= 1'b0;
        regen_ptr     <= (regen_ptr == LAST) ? '0 : regen_ptr + 1'b1;
      end
      if (startOfFrame) begin
        if (frame_cnt == FR_LAST) begin
          frame_cnt     <= '0;
          regen_pending <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shield_array.sv
// tb/tb_shield_array.sv - randomized bench for shield_array against a cell-array model
module tb_shield_array;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        playGame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        collisionPlayerShot = 1'b0;
  logic        collisionAlienShot = 1'b0;
  logic        shieldDR;
  logic [7:0]  shieldRGB;
  logic        clearBusy;

  int checks = 0;
  int errors = 0;

  int m_hp [512];
  bit m_play = 0;
  int m_ptr = 0;

  shield_array #(.REGEN_FRAMES(2)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
    .pixelX(pixelX), .pixelY(pixelY),
    .collisionPlayerShot(collisionPlayerShot), .collisionAlienShot(collisionAlienShot),
    .shieldDR(shieldDR), .shieldRGB(shieldRGB), .clearBusy(clearBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int init_of(input int c);
    int row, col;
    row = (c / 16) % 8;
    col = c % 16;
    if (row >= 6 && col >= 4 && col < 12) return 0;
    return 3;
  endfunction

  function automatic int cell_of(input int x, input int y);
    int dx, s, lx;
    if (x < 96 || y < 356 || y >= 388) return -1;
    dx = x - 96;
    s  = dx / 128;
    lx = dx % 128;
    if (s >= 4 || lx >= 64) return -1;
    return s * 128 + ((y - 356) / 4) * 16 + lx / 4;
  endfunction

  function automatic int exp_rgb(input int hp);
    if (hp > 1) return 'h1C;
    if (hp > 0) return 'h10;
    return 0;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 512; i++) m_hp[i] = init_of(i);
  endtask

  task automatic set_pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
  endtask

  task automatic show(input int c);
    set_pix(96 + (c / 128) * 128 + (c % 16) * 4 + $urandom_range(0, 3),
            356 + ((c / 16) % 8) * 4 + $urandom_range(0, 3));
    tick();
  endtask

  task automatic check_pix(input string tag, input int x, input int y);
    int c, hp;
    set_pix(x, y);
    tick();
    c  = cell_of(x, y);
    hp = (c < 0) ? 0 : m_hp[c];
    check({tag, "_dr"}, int'(shieldDR), int'(hp != 0));
    check({tag, "_rgb"}, int'(shieldRGB), exp_rgb(hp));
  endtask

  task automatic check_cell(input string tag, input int c);
    show(c);
    check({tag, "_dr"}, int'(shieldDR), int'(m_hp[c] != 0));
    check({tag, "_rgb"}, int'(shieldRGB), exp_rgb(m_hp[c]));
  endtask

  task automatic hit(input int c, input bit p, input bit a);
    int nh;
    show(c);
    collisionPlayerShot = p;
    collisionAlienShot  = a;
    tick();
    collisionPlayerShot = 0;
    collisionAlienShot  = 0;
    if (m_play && m_hp[c] != 0 && (p || a)) begin
      nh = m_hp[c] - (p ? 1 : 0) - (a ? 2 : 0);
      m_hp[c] = (nh < 0) ? 0 : nh;
    end
    check("hit_dr", int'(shieldDR), int'(m_hp[c] != 0));
    check("hit_rgb", int'(shieldRGB), exp_rgb(m_hp[c]));
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (clearBusy && n < 2000) begin
      tick();
      n++;
    end
    check(tag, n, 512);
  endtask

  task automatic regen_step();
    startOfFrame = 1; tick();
    tick();
    startOfFrame = 0; tick();
    if (m_hp[m_ptr] < init_of(m_ptr)) m_hp[m_ptr]++;
    m_ptr = (m_ptr + 1) % 512;
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 512; c++) check_cell(tag, c);
  endtask

  initial begin
    int c;
    reset_model();
    repeat (3) tick();
    check("rst_busy", int'(clearBusy), 1);
    check("rst_dr", int'(shieldDR), 0);
    check("rst_rgb", int'(shieldRGB), 0);
    resetN = 1;
    wait_clear("clear_len_reset");

    check_pix("corner", 96, 356);
    check("corner_rgb_abs", int'(shieldRGB), 'h1C);
    for (int x = 0; x < 700; x++) check_pix("row380", x, 380);
    check_pix("s4", 608, 360);
    for (int i = 0; i < 300; i++)
      check_pix("rnd_pix", $urandom_range(0, 700), $urandom_range(340, 400));

    hit(5, 1, 1);

    playGame = 1;
    tick();
    m_play = 1;

    hit(17, 1, 0);
    check("h1_rgb", int'(shieldRGB), 'h1C);
    hit(17, 1, 0);
    check("h2_rgb", int'(shieldRGB), 'h10);
    hit(17, 1, 0);
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++) begin
        set_pix(100 + ox, 360 + oy);
        tick();
        check("dead_cell_dr", int'(shieldDR), 0);
      end
    hit(17, 1, 1);
    hit(145, 1, 1);
    check("combo_dr", int'(shieldDR), 0);
    hit(146, 1, 0);
    hit(146, 1, 0);
    hit(146, 0, 1);
    check("sat_dr", int'(shieldDR), 0);
    hit(100, 1, 1);

    for (int i = 0; i < 60; i++) begin
      c = $urandom_range(2, 511);
      hit(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    hit(0, 1, 0);
    hit(0, 1, 0);
    regen_step();
    check_cell("regen0", 0);
    check("regen0_rgb_abs", int'(shieldRGB), 'h1C);

    hit(1, 1, 0);
    hit(1, 1, 0);
    show(1);
    startOfFrame = 1; tick();
    tick();
    startOfFrame = 0; collisionPlayerShot = 1; tick();
    collisionPlayerShot = 0;
    check("regen_defer_dr", int'(shieldDR), 0);
    tick();
    check("regen_retry_dr", int'(shieldDR), 1);
    check("regen_retry_rgb", int'(shieldRGB), 'h10);
    m_hp[1] = 1;
    m_ptr = 2;

    while (m_ptr <= 100) regen_step();
    check_cell("arch_regen", 100);
    check_all("after_regen");

    show(2);
    playGame = 0;
    tick();
    check("clear_enter", int'(clearBusy), 1);
    check("clear_dr", int'(shieldDR), 0);
    m_play = 0;
    reset_model();
    wait_clear("clear_len_drop");
    check_all("after_clear");

    playGame = 1; tick();
    playGame = 0; tick();
    repeat (100) tick();
    resetN = 0;
    tick(); tick();
    check("midclear_busy", int'(clearBusy), 1);
    resetN = 1;
    wait_clear("clear_len_restart");
    for (int i = 0; i < 64; i++) check_cell("post_restart", $urandom_range(0, 511));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shield_array.md
Name: shield_array

Overview:
- Parametrised successor of the single-rectangle shield block. Draws NUM_SHIELDS independent bunkers in one horizontal row.
- Each bunker is a grid of CELL×CELL pixel cells. Every cell holds a multi-level hit-point (HP) value.
- Shots from the player and from aliens erode cells by different amounts. Optional timed regeneration restores cells.
- Sits between the VGA pixel counters and the object mux, like the other *_block drawers.

Parameters:
- NUM_SHIELDS, 4, number of bunkers.
- TOPLEFT_X, 96, x of the first bunker's left edge.
- TOPLEFT_Y, 356, y of all bunkers' top edge.
- PITCH_LOG2, 7, log2 of the horizontal distance between bunker left edges (128 px).
- SHIELD_W, 64, bunker width in px; must be a multiple of CELL and ≤ 2^PITCH_LOG2.
- SHIELD_H, 32, bunker height in px; must be a multiple of CELL.
- CELL_LOG2, 2, log2 of the cell edge (CELL = 4 px).
- HP_BITS, 2, width of the per-cell HP field.
- MAX_HP, 3, initial HP of a solid cell.
- PLAYER_DMG, 1, HP removed per player-shot hit.
- ALIEN_DMG, 2, HP removed per alien-shot hit.
- ARCH_ROWS, 2, bottom cell rows whose middle half of columns start at HP 0 (the arch); 0 gives a solid bunker.
- REGEN_FRAMES, 60, frames between regeneration steps; 0 disables regeneration.
- COLOR_HI, 8'h1C, RGB for HP > MAX_HP/2.
- COLOR_LO, 8'h10, RGB for 0 < HP ≤ MAX_HP/2.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- playGame  in  1  high while a game is in progress.
- pixelX  in  11  current pixel x.
- pixelY  in  11  current pixel y.
- collisionPlayerShot  in  1  player shot overlaps shieldDR this cycle.
- collisionAlienShot  in  1  alien shot overlaps shieldDR this cycle.
- shieldDR  out  1  drawing request.
- shieldRGB  out  8  pixel colour (RRRGGGBB).
- clearBusy  out  1  high while the cell memory is being refilled.

Behaviour:
- Cell memory: NUM_SHIELDS·(SHIELD_W/CELL)·(SHIELD_H/CELL) entries, each HP_BITS wide. Default is 512 entries.
- Address decode, combinational:
  - dx = pixelX−TOPLEFT_X, dy = pixelY−TOPLEFT_Y.
  - shield index s = dx>>PITCH_LOG2; local x lx = dx[PITCH_LOG2-1:0].
  - Inside when pixelX ≥ TOPLEFT_X, s < NUM_SHIELDS, lx < SHIELD_W, and 0 ≤ dy < SHIELD_H.
  - cell = {s, dy>>CELL_LOG2, lx>>CELL_LOG2}.
- Pipeline: inside, cell address and HP are registered.
  - shieldDR and shieldRGB are valid 1 clk after the pixel, and are registered outputs.
  - The registered cell address is the damage target.
- shieldDR = inside_q & HP_q≠0 & state≠CLEAR.
- shieldRGB = COLOR_HI or COLOR_LO per the HP thresholds; 8'h00 when shieldDR=0.
- FSM states: CLEAR, IDLE, PLAY. Reset enters CLEAR.
  - CLEAR: a sweep counter writes one cell per clk with its initial value: MAX_HP, or 0 if in the arch region. clearBusy=1. Collisions are ignored. After the last cell, go to IDLE.
  - IDLE: bunkers are drawn and memory is frozen. If playGame=1, go to PLAY.
  - PLAY: damage and regeneration are active. If playGame=0, go to CLEAR, so bunkers are whole for the next standby/game.
  - Reset asserted mid-sweep or mid-game restarts CLEAR from cell 0.
- Damage, in PLAY and only when shieldDR=1:
  - new HP = HP_q − (collisionPlayerShot?PLAYER_DMG:0) − (collisionAlienShot?ALIEN_DMG:0).
  - Compute in HP_BITS+2 bits and saturate at 0.
  - Write to the registered address in the same clk.
  - Collision inputs with shieldDR=0 have no effect.
- Regeneration, only if REGEN_FRAMES≠0:
  - A frame counter counts startOfFrame in PLAY; it is cleared in other states.
  - On reaching REGEN_FRAMES it sets regenPending and resets to 0.
  - While regenPending is set, the cell at the regen pointer gets HP+1, saturating at that cell's initial value, so arch cells never grow.
  - The pointer then advances and wraps from the last cell to 0. regenPending clears.
  - A damage write in the same clk has priority; regen retries next clk.
  - If the pointer cell is the damage target, damage wins.
- Reset values: shieldDR=0, shieldRGB=0, clearBusy=1, frame counter=0, regen pointer=0, regenPending=0.

Test Plan:
- Reset, then idle clocks. Expect clearBusy=1 for exactly 512 clks, then 0 and state IDLE. Pixel (96,356) gives shieldDR=1, RGB=8'h1C one clk later.
- Pixel sweep of row y=380, with the arch at y 380–387. x 96–111 drawn; x 112–143 not drawn (arch); x 144–159 drawn; x 160–223 not drawn (gap). Repeat for shields 1–3 at +128 steps. x 608 not drawn (s=4).
- In PLAY, one player hit on the cell at (100,360). Its HP goes 3→2: RGB stays 8'h1C. A second hit gives HP 1 and RGB 8'h10. A third hit gives HP 0 and shieldDR=0 thereafter for all 16 px of that cell.
- Player and alien hits in the same clk on a full cell: HP 3−1−2=0. A single alien hit on an HP 1 cell saturates to 0, with no wrap to 3.
- REGEN_FRAMES=2, cell 0 damaged to HP 1, pointer at 0. After 2 startOfFrame pulses in PLAY, cell 0 HP is 2.
  - A collision asserted on the regen clk delays regen by 1 clk.
  - An arch cell at the pointer stays 0.
- Damage several cells, then drop playGame. Expect CLEAR for 512 clks, then all cells back to initial values. Assert resetN low mid-CLEAR: clearBusy stays 1 and the sweep restarts at 0.
